// File: rtl/fx3_pkg.sv
// Shared types and default constants for the FX3 GPIF burst scheduler.
package fx3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WRITE,
        ST_WM_DRAIN,
        ST_TURNAROUND
    } state_t;

    localparam int BURST_LEN_DEF  = 8192;
    localparam int WM_LATENCY_DEF = 3;
    localparam int TURNAROUND_DEF = 2;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/sat_event_counter.sv
// Event counter that counts one per cycle with inc high and holds at all-ones.
module sat_event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fx3_burst_scheduler.sv
// Burst state machine gating FIFO reads onto FX3 GPIF thread 0 with watermark drain,
// turnaround gaps and saturating overflow/underrun/abort counters.
module fx3_burst_scheduler #(
    parameter int BURST_LEN  = fx3_pkg::BURST_LEN_DEF,
    parameter int WM_LATENCY = fx3_pkg::WM_LATENCY_DEF,
    parameter int TURNAROUND = fx3_pkg::TURNAROUND_DEF,
    parameter int CNT_W      = fx3_pkg::CNT_W
) (
    input  logic             fx3_clock,
    input  logic             fx3_nReset,
    input  logic             fx3_nReady,
    input  logic             fx3_th0Ready,
    input  logic             fx3_th0Watermark,
    input  logic             fifoEmpty,
    input  logic             fifoHalfFull,
    input  logic             fifoFull,
    output logic             fx3_nWrite,
    output logic             fifoReadAck,
    output logic             burstActive,
    output logic [CNT_W-1:0] overflowCount,
    output logic [CNT_W-1:0] underrunCount,
    output logic [CNT_W-1:0] abortCount
);
    import fx3_pkg::*;

    localparam int WC_W = $clog2(BURST_LEN + 1);
    localparam int DR_W = $clog2(WM_LATENCY + 1);
    localparam int TA_W = $clog2(TURNAROUND + 1);

    state_t          state_q, state_d;
    logic [WC_W-1:0] word_q, word_d;
    logic [DR_W-1:0] drain_q, drain_d;
    logic [TA_W-1:0] ta_q, ta_d;
    logic            nwrite_q, nwrite_d;
    logic            active_q, active_d;
    logic            wm_q, full_q;
    logic            wm_rise, full_rise, underrun_inc, abort_inc;

    assign wm_rise   = fx3_th0Watermark && !wm_q;
    assign full_rise = fifoFull && !full_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        word_d       = word_q;
        drain_d      = drain_q;
        ta_d         = ta_q;
        nwrite_d     = 1'b1;
        underrun_inc = 1'b0;
        abort_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fx3_nReady && fifoHalfFull) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (fx3_nReady) state_d = ST_IDLE;
                else if (!fx3_th0Ready && !fifoEmpty) state_d = ST_WRITE;
            end
            ST_WRITE, ST_WM_DRAIN: begin
                nwrite_d     = fifoEmpty;
                underrun_inc = fifoEmpty;
                if (!fifoEmpty) word_d = word_q + WC_W'(1);
                // Terminal count wins over the watermark; the drain count includes this cycle's word.
                if (!fifoEmpty && (word_q == WC_W'(BURST_LEN - 1))) begin
                    state_d = ST_TURNAROUND;
                end else if (state_q == ST_WM_DRAIN) begin
                    if (!fifoEmpty) begin
                        drain_d = drain_q - DR_W'(1);
                        if (drain_q == DR_W'(1)) state_d = ST_TURNAROUND;
                    end
                end else if (wm_rise) begin
                    drain_d = DR_W'(WM_LATENCY) - DR_W'(!fifoEmpty);
                    state_d = (drain_d == '0) ? ST_TURNAROUND : ST_WM_DRAIN;
                end
            end
            ST_TURNAROUND: begin
                word_d = '0;
                ta_d   = ta_q + TA_W'(1);
                if (ta_q == TA_W'(TURNAROUND - 1)) begin
                    ta_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fx3_nReady && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            nwrite_d     = 1'b1;
            word_d       = '0;
            ta_d         = '0;
            underrun_inc = 1'b0;
            abort_inc    = (state_q == ST_WRITE) || (state_q == ST_WM_DRAIN);
        end

        // Kept high through the last word even though the state has already moved on.
        active_d = (state_d == ST_WRITE) || (state_d == ST_WM_DRAIN) || !nwrite_d;
    end

    always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
        if (!fx3_nReset) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            drain_q  <= '0;
            ta_q     <= '0;
            nwrite_q <= 1'b1;
            active_q <= 1'b0;
            wm_q     <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            drain_q  <= drain_d;
            ta_q     <= ta_d;
            nwrite_q <= nwrite_d;
            active_q <= active_d;
            wm_q     <= fx3_th0Watermark;
            full_q   <= fifoFull;
        end
    end

    assign fx3_nWrite  = nwrite_q;
    assign fifoReadAck = !nwrite_q;
    assign burstActive = active_q;

    sat_event_counter #(.WIDTH(CNT_W)) u_overflow_cnt (
        .clock(fx3_clock), .nReset(fx3_nReset), .inc(full_rise), .count(overflowCount)
    );
    sat_event_counter #(.WIDTH(CNT_W)) u_underrun_cnt (
        .clock(fx3_clock), .nReset(fx3_nReset), .inc(underrun_inc), .count(underrunCount)
    );
    sat_event_counter #(.WIDTH(CNT_W)) u_abort_cnt (
        .clock(fx3_clock), .nReset(fx3_nReset), .inc(abort_inc), .count(abortCount)
    );

endmodule

// File: tb/tb_fx3_burst_scheduler.sv
// Bench for fx3_burst_scheduler: reactive stimulus, burst shapes and event counts predicted from the rules.
module tb_fx3_burst_scheduler;

    localparam int BL  = 16;
    localparam int WML = 3;
    localparam int TA  = 2;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic n_ready = 1'b0, th0_ready = 1'b0, wm = 1'b0, empty = 1'b0, half = 1'b0, full = 1'b0;
    logic nwrite, ack, active, nwrite4, ack4, active4;
    logic [15:0] ovf, und, abt;
    logic [3:0]  ovf4, und4, abt4;

    int tests = 0, fails = 0;
    int exp_ovf = 0, exp_und = 0, exp_abt = 0;
    bit trace[$];
    int ack_bad, active_bad;

    always #5 clk = ~clk;

    fx3_burst_scheduler #(.BURST_LEN(BL), .WM_LATENCY(WML), .TURNAROUND(TA), .CNT_W(16)) dut (
        .fx3_clock(clk), .fx3_nReset(n_reset), .fx3_nReady(n_ready), .fx3_th0Ready(th0_ready),
        .fx3_th0Watermark(wm), .fifoEmpty(empty), .fifoHalfFull(half), .fifoFull(full),
        .fx3_nWrite(nwrite), .fifoReadAck(ack), .burstActive(active),
        .overflowCount(ovf), .underrunCount(und), .abortCount(abt)
    );

    fx3_burst_scheduler #(.BURST_LEN(BL), .WM_LATENCY(WML), .TURNAROUND(TA), .CNT_W(4)) dut4 (
        .fx3_clock(clk), .fx3_nReset(n_reset), .fx3_nReady(n_ready), .fx3_th0Ready(th0_ready),
        .fx3_th0Watermark(wm), .fifoEmpty(empty), .fifoHalfFull(half), .fifoFull(full),
        .fx3_nWrite(nwrite4), .fifoReadAck(ack4), .burstActive(active4),
        .overflowCount(ovf4), .underrunCount(und4), .abortCount(abt4)
    );

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    function automatic int first_low();
        foreach (trace[i]) if (trace[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int run_len(input int from, input bit val);
        int n = 0;
        for (int i = from; i < trace.size() && trace[i] == val; i++) n++;
        return n;
    endfunction

    // Total words written and high cycles between the first and last written word.
    task automatic burst_shape(output int lows, output int inner_highs);
        int f = -1, l = -1;
        lows = 0;
        foreach (trace[i]) if (trace[i] == 1'b0) begin
            lows++;
            if (f < 0) f = i;
            l = i;
        end
        inner_highs = (f < 0) ? 0 : (l - f + 1) - lows;
    endtask

    // Samples nWrite on falling edges and reacts to the running word count like the host/FIFO would.
    task automatic observe(input int cycles, input int wm_after, input int stall_after,
                           input int stall_len, input int abort_after, input bit one_shot);
        int words = 0, stall_left = 0;
        trace.delete();
        ack_bad = 0;
        active_bad = 0;
        half = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            trace.push_back(nwrite);
            if (ack !== !nwrite || nwrite4 !== nwrite || ack4 !== ack || active4 !== active) ack_bad++;
            if (nwrite === 1'b0 && active !== 1'b1) active_bad++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) empty = 1'b0;
            end
            if (nwrite === 1'b0) begin
                words++;
                if (one_shot) half = 1'b0;
                if (words == wm_after) wm = 1'b1;
                if (words == stall_after) begin
                    empty = 1'b1;
                    stall_left = stall_len;
                end
                if (words == abort_after) n_ready = 1'b1;
            end
        end
        half = 1'b0;
        wm = 1'b0;
        empty = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (nwrite !== 1'b1) begin fails++; $display("FAIL reset_nwrite: got %b want 1", nwrite); end
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", ack); end
        tests++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", active); end
        tests++; if ({ovf, und, abt} !== 48'd0) begin fails++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", ovf, und, abt); end
        n_reset = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (nwrite !== 1'b1) begin fails++; $display("FAIL reset_idle_hold: got %b want 1", nwrite); end
    endtask

    task automatic test_basic_burst();
        int f, r1, g, r2;
        observe(50, 0, 0, 0, 0, 1'b0);
        repeat (30) @(negedge clk);
        f  = first_low();
        r1 = (f < 0) ? 0 : run_len(f, 1'b0);
        g  = (f < 0) ? 0 : run_len(f + r1, 1'b1);
        r2 = (f < 0) ? 0 : run_len(f + r1 + g, 1'b0);
        tests++; if (r1 != BL) begin fails++; $display("FAIL basic_run1: got %0d words want %0d", r1, BL); end
        // Turnaround cycles, then one cycle each back through IDLE and ARM before the next word.
        tests++; if (g != TA + 2) begin fails++; $display("FAIL basic_gap: got %0d want %0d", g, TA + 2); end
        tests++; if (r2 != BL) begin fails++; $display("FAIL basic_run2: got %0d words want %0d", r2, BL); end
        tests++; if (ack_bad != 0) begin fails++; $display("FAIL basic_ack: got %0d bad cycles want 0", ack_bad); end
        tests++; if (active_bad != 0) begin fails++; $display("FAIL basic_active: got %0d bad cycles want 0", active_bad); end
    endtask

    task automatic test_watermark();
        int lows, gaps;
        observe(40, 10, 0, 0, 0, 1'b1);
        burst_shape(lows, gaps);
        tests++; if (lows != 10 + WML || gaps != 0) begin fails++; $display("FAIL wm_drain: got %0d words %0d gaps want %0d 0", lows, gaps, 10 + WML); end
        observe(40, BL - 1, 0, 0, 0, 1'b1);
        burst_shape(lows, gaps);
        tests++; if (lows != BL || gaps != 0) begin fails++; $display("FAIL wm_at_terminal: got %0d words %0d gaps want %0d 0", lows, gaps, BL); end
    endtask

    task automatic test_underrun();
        int lows, gaps;
        observe(40, 0, 6, 3, 0, 1'b1);
        exp_und += 3;
        burst_shape(lows, gaps);
        tests++; if (lows != BL) begin fails++; $display("FAIL underrun_words: got %0d want %0d", lows, BL); end
        tests++; if (gaps != 3) begin fails++; $display("FAIL underrun_stall_cycles: got %0d want 3", gaps); end
        tests++; if (und != 16'(exp_und)) begin fails++; $display("FAIL underrun_count: got %0d want %0d", und, exp_und); end
    endtask

    task automatic test_abort();
        int lows, gaps, f;
        observe(40, 0, 0, 0, 5, 1'b1);
        exp_abt++;
        burst_shape(lows, gaps);
        f = first_low();
        tests++; if (lows != 5) begin fails++; $display("FAIL abort_words: got %0d want 5", lows); end
        tests++; if (f < 0 || f + 5 >= trace.size() || trace[f + 5] != 1'b1) begin fails++; $display("FAIL abort_next_edge: first low at %0d, nWrite after word 5 not high", f); end
        tests++; if (abt != 16'(exp_abt) || abt4 != 4'(sat(exp_abt, 4))) begin fails++; $display("FAIL abort_count: got %0d/%0d want %0d", abt, abt4, exp_abt); end
        n_ready = 1'b0;
        observe(40, 0, 0, 0, 0, 1'b1);
        burst_shape(lows, gaps);
        tests++; if (lows != BL || gaps != 0) begin fails++; $display("FAIL abort_recover: got %0d words want %0d", lows, BL); end
    endtask

    task automatic test_random_bursts();
        int lows, gaps, wm_after, st_after, st_len, exp_words, exp_stall;
        for (int it = 0; it < 8; it++) begin
            wm_after = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BL - 1)) : 0;
            st_after = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BL - 1)) : 0;
            st_len   = $urandom_range(1, 4);
            exp_words = (wm_after == 0) ? BL : ((wm_after + WML < BL) ? wm_after + WML : BL);
            exp_stall = (st_after != 0 && st_after < exp_words) ? st_len : 0;
            exp_und  += exp_stall;
            observe(40, wm_after, st_after, st_len, 0, 1'b1);
            burst_shape(lows, gaps);
            tests++; if (lows != exp_words || gaps != exp_stall) begin fails++; $display("FAIL rand_burst[%0d] wm=%0d stall=%0d/%0d: got %0d words %0d stalls want %0d %0d", it, wm_after, st_after, st_len, lows, gaps, exp_words, exp_stall); end
            tests++; if (und != 16'(exp_und) || und4 != 4'(sat(exp_und, 4))) begin fails++; $display("FAIL rand_underrun[%0d]: got %0d/%0d want %0d", it, und, und4, exp_und); end
        end
    endtask

    task automatic test_overflow_saturation();
        for (int p = 0; p < 25; p++) begin
            full = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            full = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            exp_ovf++;
            if (p == 4) begin
                tests++; if (ovf != 16'd5 || ovf4 != 4'd5) begin fails++; $display("FAIL overflow_5: got %0d/%0d want 5/5", ovf, ovf4); end
            end
        end
        tests++; if (ovf != 16'(exp_ovf)) begin fails++; $display("FAIL overflow_25: got %0d want %0d", ovf, exp_ovf); end
        tests++; if (ovf4 != 4'(sat(exp_ovf, 4))) begin fails++; $display("FAIL overflow_sat: got %0d want %0d", ovf4, sat(exp_ovf, 4)); end
    endtask

    task automatic test_async_reset();
        int budget = 20, lows, gaps, stray = 0;
        half = 1'b1;
        do @(negedge clk); while (nwrite !== 1'b0 && --budget > 0);
        tests++; if (nwrite !== 1'b0) begin fails++; $display("FAIL async_burst_start: got nWrite %b want 0 within 20 cycles", nwrite); end
        repeat (3) @(negedge clk);
        #1 n_reset = 1'b0;
        half = 1'b0;
        #1;
        tests++; if (nwrite !== 1'b1 || ack !== 1'b0 || active !== 1'b0) begin fails++; $display("FAIL async_outputs: got nWrite %b ack %b active %b want 1 0 0", nwrite, ack, active); end
        tests++; if ({ovf, und, abt, ovf4, und4, abt4} !== 60'd0) begin fails++; $display("FAIL async_counters: got %0d/%0d/%0d want 0", ovf, und, abt); end
        #1 n_reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (nwrite !== 1'b1) stray++;
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL async_stay_idle: got %0d write cycles want 0", stray); end
        observe(40, 0, 0, 0, 0, 1'b1);
        burst_shape(lows, gaps);
        tests++; if (lows != BL) begin fails++; $display("FAIL async_rearm: got %0d words want %0d", lows, BL); end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_watermark();
        test_underrun();
        test_abort();
        test_random_bursts();
        test_overflow_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
